clock_enable_gen: RTL and testbench

- Runs in the PLL output clock domain and converts the raw PLL clock into NUM_CH exact-average clock-enable pulse trains using fractional phase accumulators.
- Example: 4.194304 MHz Game Boy CPU rate derived from the 16.875 MHz PLL output.
- Qualifies the PLL lock signal and sequences a synchronous system reset (rst_out_n) for all downstream logic.
- Supports runtime retuning of each channel's step, e.g. for CGB double-speed mode, and a global pause.

---
 rtl/clock_enable_gen.sv | 141 ++++++++++++++
 tb/tb_clock_enable_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_gen.sv
// PLL-domain clock-enable generator: lock qualification, downstream reset
// sequencing and NUM_CH fractional phase-accumulator enable channels.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_WAIT | PLL not locked; downstream held in reset, accumulators at 0
// ST_COUNT| locked_s seen; counting consecutive locked cycles
// ST_RUN  | lock qualified; reset released, enables running
module clock_enable_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_WIDTH   = 24,
  parameter logic [NUM_CH*ACC_WIDTH-1:0] STEP_INIT = {NUM_CH{24'd4170000}},
  parameter int LOCK_CYCLES = 1024,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W      = $clog2(LOCK_CYCLES)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 locked,
  input  logic                 pause,
  input  logic                 step_wr,
  input  logic [SEL_W-1:0]     step_sel,
  input  logic [ACC_WIDTH-1:0] step_data,
  input  logic                 clear_status,
  output logic [NUM_CH-1:0]    ce,
  output logic                 rst_out_n,
  output logic                 running,
  output logic                 lock_lost
);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  logic                 r_sync1;
  logic                 r_locked_s;
  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_rst_out_n;
  logic                 r_running;
  logic                 r_lock_lost;
  logic [ACC_WIDTH-1:0] r_acc  [NUM_CH];
  logic [ACC_WIDTH-1:0] r_step [NUM_CH];
  logic [ACC_WIDTH:0]   w_sum  [NUM_CH];
  logic [NUM_CH-1:0]    r_ce;
  logic                 w_acc_run;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= locked;
      r_locked_s <= r_sync1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT:  if (r_locked_s) w_state_next = ST_COUNT;
      ST_COUNT: begin
        if (!r_locked_s)
          w_state_next = ST_WAIT;
        else if (r_cnt == CNT_W'(LOCK_CYCLES - 1))
          w_state_next = ST_RUN;
      end
      ST_RUN:   if (!r_locked_s) w_state_next = ST_WAIT;
      default:  w_state_next = ST_WAIT;
    endcase
  end

  // The counter already holds 1 on entry to COUNT: the WAIT cycle that saw
  // locked_s counts towards the qualification window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_WAIT;
      r_cnt       <= '0;
      r_rst_out_n <= 1'b0;
      r_running   <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rst_out_n <= (w_state_next == ST_RUN);
      r_running   <= (w_state_next == ST_RUN);
      if (w_state_next == ST_COUNT)
        r_cnt <= (r_state == ST_COUNT) ? r_cnt + CNT_W'(1) : CNT_W'(1);
      else
        r_cnt <= '0;
      if (r_state == ST_RUN && w_state_next != ST_RUN)
        r_lock_lost <= 1'b1;
      else if (clear_status)
        r_lock_lost <= 1'b0;
    end
  end

  // Accumulate only while staying in RUN so ce drops on the same cycle
  // as rst_out_n when lock is lost.
  assign w_acc_run = (r_state == ST_RUN) && (w_state_next == ST_RUN);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_step[i]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ce <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i]  <= '0;
        r_step[i] <= STEP_INIT[i*ACC_WIDTH +: ACC_WIDTH];
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_acc_run) begin
          if (!pause) begin
            r_acc[i] <= w_sum[i][ACC_WIDTH-1:0];
            r_ce[i]  <= w_sum[i][ACC_WIDTH];
          end else begin
            r_ce[i]  <= 1'b0;
          end
        end else begin
          r_acc[i] <= '0;
          r_ce[i]  <= 1'b0;
        end
        // Out-of-range selects match no channel and are dropped.
        if (step_wr && step_sel == SEL_W'(i))
          r_step[i] <= step_data;
      end
    end
  end

  assign ce        = r_ce;
  assign rst_out_n = r_rst_out_n;
  assign running   = r_running;
  assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Bench for clock_enable_gen: phase-sum reference model checked every cycle,
// directed lock/divide/retune/pause scenarios, then randomized traffic.
module tb_clock_enable_gen;

  localparam int NCH  = 3;
  localparam int W    = 8;
  localparam int LOCK = 8;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           locked = 1'b0;
  logic           pause = 1'b0;
  logic           step_wr = 1'b0;
  logic [1:0]     step_sel = '0;
  logic [W-1:0]   step_data = '0;
  logic           clear_status = 1'b0;
  logic [NCH-1:0] ce;
  logic           rst_out_n;
  logic           running;
  logic           lock_lost;

  int n_checks = 0;
  int n_err    = 0;

  clock_enable_gen #(
    .NUM_CH(NCH), .ACC_WIDTH(W),
    .STEP_INIT({8'd200, 8'd3, 8'd64}),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .clock(clock), .reset_n(reset_n), .locked(locked), .pause(pause),
    .step_wr(step_wr), .step_sel(step_sel), .step_data(step_data),
    .clear_status(clear_status), .ce(ce), .rst_out_n(rst_out_n),
    .running(running), .lock_lost(lock_lost)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: lock qualified after LOCK consecutive synchronised-high
  // samples; each channel keeps an unbounded phase sum, a pulse is emitted
  // whenever the sum crosses a multiple of 2^W.
  bit       m_s1, m_s2, m_run, m_ll;
  int       m_run_len;
  longint   m_total [NCH];
  int       m_step  [NCH];
  logic [NCH-1:0] m_ce;

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      m_s1 = 0; m_s2 = 0; m_run = 0; m_ll = 0; m_run_len = 0; m_ce = '0;
      m_step[0] = 64; m_step[1] = 3; m_step[2] = 200;
      for (int c = 0; c < NCH; c++) m_total[c] = 0;
    end else begin
      bit ls, prev;
      longint old;
      ls = m_s2; m_s2 = m_s1; m_s1 = locked;
      prev = m_run;
      if (ls) begin
        if (m_run_len < 1000000) m_run_len++;
      end else m_run_len = 0;
      m_run = (m_run_len >= LOCK);
      for (int c = 0; c < NCH; c++) begin
        if (prev && m_run && !pause) begin
          old = m_total[c];
          m_total[c] = m_total[c] + m_step[c];
          m_ce[c] = ((m_total[c] >> W) != (old >> W));
        end else begin
          if (!(prev && m_run)) m_total[c] = 0;
          m_ce[c] = 1'b0;
        end
      end
      if (prev && !m_run) m_ll = 1;
      else if (clear_status) m_ll = 0;
      if (step_wr && step_sel < NCH) m_step[step_sel] = step_data;
    end
  end

  initial forever begin
    @(negedge clock);
    if (reset_n) begin
      check("model_ce", ce, m_ce);
      check("model_rst_out_n", rst_out_n, m_run);
      check("model_running", running, m_run);
      check("model_lock_lost", lock_lost, m_ll);
    end
  end

  task automatic wait_running(output int cyc);
    cyc = 0;
    while (!running && cyc < 200) begin
      @(posedge clock); #1; cyc++;
    end
  endtask

  task automatic first_ce0(output int k);
    k = 0;
    while (!ce[0] && k < 50) begin
      @(posedge clock); #1; k++;
    end
  endtask

  initial begin
    int cyc, k, first0, cnt0, n, drop_cnt, in_win;
    int t1[$];

    repeat (3) @(negedge clock);
    check("reset_ce", ce, 0);
    check("reset_rst_out_n", rst_out_n, 0);
    check("reset_running", running, 0);
    check("reset_lock_lost", lock_lost, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Lock sequencing, exact divide on ch0 and fractional rate on ch1.
    locked = 1'b1;
    wait_running(cyc);
    check("lock_latency", cyc, 10);
    check("rst_out_n_after_lock", rst_out_n, 1);
    first0 = -1; cnt0 = 0;
    for (int i = 1; i <= 800; i++) begin
      @(posedge clock); #1;
      if (ce[0]) begin
        if (first0 < 0) first0 = i;
        if (i <= 400) cnt0++;
      end
      if (ce[1]) t1.push_back(i);
    end
    check("ch0_first_pulse", first0, 4);
    check("ch0_pulses_400", cnt0, 100);
    check("ch1_first_pulse", t1[0], 86);
    in_win = 0;
    foreach (t1[i]) if (t1[i] <= 256) in_win++;
    check("ch1_pulses_256", in_win, 3);
    for (int i = 0; i + 1 < t1.size(); i++)
      check("ch1_interval_85_86", (t1[i+1]-t1[i] == 85) || (t1[i+1]-t1[i] == 86), 1);
    for (int i = 0; i + 3 < t1.size(); i++)
      check("ch1_period_256", t1[i+3] - t1[i], 256);

    // Retune ch0 to 128: every second cycle, no phase reset.
    @(negedge clock);
    step_wr = 1'b1; step_sel = 2'd0; step_data = 8'd128;
    @(negedge clock);
    step_wr = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (ce[0]) n++;
    end
    check("ch0_retuned_pulses_40", n, 20);

    @(negedge clock);
    pause = 1'b1;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clock); #1;
      if (ce != '0) n++;
    end
    check("pause_no_ce", n, 0);
    @(negedge clock);
    pause = 1'b0;
    repeat (30) @(negedge clock);

    step_wr = 1'b1; step_sel = 2'd3; step_data = 8'd1;
    @(negedge clock);
    step_wr = 1'b0;
    repeat (20) @(negedge clock);

    // Lock loss in RUN.
    locked = 1'b0;
    cyc = 0;
    while (running && cyc < 20) begin
      @(posedge clock); #1; cyc++;
    end
    check("lock_loss_latency", cyc, 3);
    check("lock_loss_ce", ce, 0);
    check("lock_loss_rst_out_n", rst_out_n, 0);
    check("lock_lost_set", lock_lost, 1);
    repeat (5) @(negedge clock);
    check("lock_lost_sticky", lock_lost, 1);
    clear_status = 1'b1;
    @(negedge clock);
    clear_status = 1'b0;
    check("lock_lost_cleared", lock_lost, 0);

    // Glitch during qualification restarts the count.
    locked = 1'b1;
    repeat (5) @(negedge clock);
    locked = 1'b0;
    @(negedge clock);
    locked = 1'b1;
    wait_running(cyc);
    check("glitch_relock_latency", cyc, 10);
    check("glitch_lock_lost", lock_lost, 0);
    first_ce0(k);
    check("step_retained_first_pulse", k, 2);

    // Randomized traffic.
    drop_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      pause        = ($urandom_range(0, 9) == 0);
      step_wr      = ($urandom_range(0, 7) == 0);
      step_sel     = 2'($urandom_range(0, 3));
      step_data    = 8'($urandom_range(0, 255));
      clear_status = ($urandom_range(0, 15) == 0);
      if (drop_cnt > 0) begin
        drop_cnt--;
        if (drop_cnt == 0) locked = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        locked = 1'b0;
        drop_cnt = $urandom_range(1, 6);
      end
    end
    @(negedge clock);
    pause = 1'b0; step_wr = 1'b0; clear_status = 1'b0; locked = 1'b1;
    repeat (30) @(negedge clock);

    // Asynchronous reset mid-cycle, then relock with reloaded steps.
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_ce", ce, 0);
    check("async_reset_rst_out_n", rst_out_n, 0);
    check("async_reset_running", running, 0);
    check("async_reset_lock_lost", lock_lost, 0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_running(cyc);
    check("post_reset_lock_latency", cyc, 10);
    first_ce0(k);
    check("post_reset_step_reload", k, 4);
    repeat (200) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
